// File: rtl/fake_jpeg_bit_unpacker.sv
// fake_jpeg_bit_unpacker: removes 0xFF00 stuffing and 0xFF fill bytes from the
// entropy-coded stream, detects markers, and serves MSB-first bit fields of
// 0..MAX_LEN bits. The bit buffer is MSB-aligned: bit BUF_W-1 is the oldest bit.
module fake_jpeg_bit_unpacker #(
    parameter int BUF_W   = 32,
    parameter int MAX_LEN = 11
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         byte_in,
    input  logic               byte_valid,
    output logic               byte_ready,
    input  logic               req_valid,
    input  logic [3:0]         req_len,
    output logic               req_ready,
    output logic               out_valid,
    output logic [MAX_LEN-1:0] out_bits,
    output logic [5:0]         bits_avail,
    output logic               marker_valid,
    output logic [7:0]         marker_code,
    input  logic               marker_clear
);

    // Count width is tied to the 6-bit bits_avail port, so BUF_W must stay <= 63.
    localparam int CNT_W = 6;

    typedef enum logic [1:0] {NORMAL, FF_PEND, MARKER} state_t;

    state_t             state_q, state_n;
    logic [CNT_W-1:0]   count_q, count_n, rem_p0, consume_p0;
    logic [BUF_W-1:0]   bitbuf_q, bitbuf_n, win_p0;
    logic [3:0]         len_p0;
    logic               byte_fire, req_fire, append, marker_set, clear_fire;
    logic [7:0]         app_byte;
    logic [MAX_LEN-1:0] field_p0;
    logic               vld_p1;

    // Requests longer than the output port are clamped to MAX_LEN.
    function automatic logic [3:0] sat_len(input logic [3:0] l);
        return (l > 4'(MAX_LEN)) ? 4'(MAX_LEN) : l;
    endfunction

    // Leading l bits of the window, right-aligned with zero upper bits.
    function automatic logic [MAX_LEN-1:0] extract_field(input logic [BUF_W-1:0] w,
                                                         input logic [3:0] l);
        logic [MAX_LEN-1:0] top;
        top = w[BUF_W-1 -: MAX_LEN];
        return top >> (4'(MAX_LEN) - l);
    endfunction

    assign len_p0     = sat_len(req_len);
    assign byte_ready = ~rst && (state_q != MARKER) && (count_q <= CNT_W'(BUF_W-8));
    assign req_ready  = ~rst && ~marker_clear &&
                        ((state_q == MARKER) || (count_q >= CNT_W'(len_p0)));
    assign byte_fire  = byte_valid && byte_ready;
    assign req_fire   = req_valid && req_ready;
    assign clear_fire = (state_q == MARKER) && marker_clear;
    assign bits_avail = count_q;
    assign out_valid  = vld_p1;

    // Byte-stream state machine: stuffing removal, fill skipping, marker capture.
    always_comb begin
        state_n    = state_q;
        append     = 1'b0;
        app_byte   = byte_in;
        marker_set = 1'b0;
        if (byte_fire) begin
            case (state_q)
                NORMAL: begin
                    if (byte_in == 8'hFF) state_n = FF_PEND;
                    else                  append  = 1'b1;
                end
                FF_PEND: begin
                    if (byte_in == 8'h00) begin
                        append   = 1'b1;
                        app_byte = 8'hFF;
                        state_n  = NORMAL;
                    end else if (byte_in != 8'hFF) begin
                        marker_set = 1'b1;
                        state_n    = MARKER;
                    end
                end
                default: ;
            endcase
        end
        if (clear_fire) state_n = NORMAL;
    end

    // Field extraction and buffer update; after a marker, missing bits read as 1s
    // and consumption saturates the count at zero.
    always_comb begin
        win_p0     = (state_q == MARKER) ? (bitbuf_q | ({BUF_W{1'b1}} >> count_q)) : bitbuf_q;
        field_p0   = extract_field(win_p0, len_p0);
        consume_p0 = req_fire ? CNT_W'(len_p0) : '0;
        rem_p0     = (consume_p0 > count_q) ? '0 : (count_q - consume_p0);
        bitbuf_n   = (bitbuf_q << consume_p0) & ~({BUF_W{1'b1}} >> rem_p0);
        if (append) bitbuf_n = bitbuf_n | ({app_byte, {(BUF_W-8){1'b0}}} >> rem_p0);
        count_n    = rem_p0 + (append ? CNT_W'(8) : '0);
        if (clear_fire) count_n = '0;
    end

    // Buffer contents are qualified by count, so they need no reset.
    always_ff @(posedge clk) begin
        bitbuf_q <= bitbuf_n;
    end

    // Control state, output field register and marker capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= NORMAL;
            count_q      <= '0;
            vld_p1       <= 1'b0;
            out_bits     <= '0;
            marker_valid <= 1'b0;
            marker_code  <= '0;
        end else begin
            // ---- stage p0 -> p1: request served one cycle after acceptance
            state_q <= state_n;
            count_q <= count_n;
            vld_p1  <= req_fire;
            if (req_fire) out_bits <= field_p0;
            if (marker_set) begin
                marker_valid <= 1'b1;
                marker_code  <= byte_in;
            end else if (clear_fire) begin
                marker_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fake_jpeg_bit_unpacker.sv
// Directed self-checking bench for fake_jpeg_bit_unpacker.
module tb_fake_jpeg_bit_unpacker;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        req_valid;
    logic [3:0]  req_len;
    logic        req_ready;
    logic        out_valid;
    logic [10:0] out_bits;
    logic [5:0]  bits_avail;
    logic        marker_valid;
    logic [7:0]  marker_code;
    logic        marker_clear;

    int n_assert = 0;
    int n_fail   = 0;

    fake_jpeg_bit_unpacker #(.BUF_W(32), .MAX_LEN(11)) dut (
        .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .req_valid(req_valid), .req_len(req_len),
        .req_ready(req_ready), .out_valid(out_valid), .out_bits(out_bits),
        .bits_avail(bits_avail), .marker_valid(marker_valid),
        .marker_code(marker_code), .marker_clear(marker_clear)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; presents one byte for one edge, returns at the next negedge.
    task automatic put_byte(input logic [7:0] b);
        byte_in    = b;
        byte_valid = 1'b1;
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    // Called at a negedge; issues one request, returns at the next negedge and checks the result.
    task automatic do_req(input string tag, input logic [3:0] len, input logic [10:0] exp_bits);
        req_len   = len;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk({tag, "_vld"}, 32'(out_valid), 32'd1);
        chk({tag, "_bits"}, 32'(out_bits), 32'(exp_bits));
    endtask

    initial begin
        rst = 1'b1; byte_in = 8'h00; byte_valid = 1'b0;
        req_valid = 1'b0; req_len = 4'd0; marker_clear = 1'b0;
        #1;
        chk("rst_byte_ready", 32'(byte_ready), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_bits_avail", 32'(bits_avail), 32'd0);
        chk("rst_marker", 32'(marker_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_byte_ready", 32'(byte_ready), 32'd1);

        // Plain bytes and MSB-first fields
        put_byte(8'hA5);
        put_byte(8'h3C);
        chk("t1_avail16", 32'(bits_avail), 32'd16);
        do_req("t1_r4", 4'd4, 11'h00A);
        do_req("t1_r11", 4'd11, 11'h29E);
        chk("t1_avail1", 32'(bits_avail), 32'd1);
        @(negedge clk);
        chk("t1_pulse_end", 32'(out_valid), 32'd0);
        do_req("t1_drain", 4'd1, 11'h000);

        // Stuffed 0xFF00
        put_byte(8'hFF);
        chk("t2_avail0", 32'(bits_avail), 32'd0);
        put_byte(8'h00);
        chk("t2_avail8", 32'(bits_avail), 32'd8);
        put_byte(8'h12);
        chk("t2_avail16", 32'(bits_avail), 32'd16);
        do_req("t2_rA", 4'd8, 11'h0FF);
        do_req("t2_rB", 4'd8, 11'h012);

        // Fill byte before stuffing
        put_byte(8'hFF);
        put_byte(8'hFF);
        put_byte(8'h00);
        chk("t3_avail8", 32'(bits_avail), 32'd8);
        chk("t3_no_marker", 32'(marker_valid), 32'd0);
        do_req("t3_r8", 4'd8, 11'h0FF);

        // Marker: padding with 1s, then clear
        put_byte(8'h81);
        put_byte(8'hFF);
        put_byte(8'hD9);
        chk("t4_marker_valid", 32'(marker_valid), 32'd1);
        chk("t4_marker_code", 32'(marker_code), 32'hD9);
        chk("t4_byte_ready", 32'(byte_ready), 32'd0);
        do_req("t4_r11", 4'd11, 11'h40F);
        chk("t4_avail0", 32'(bits_avail), 32'd0);
        do_req("t4_r3_pad", 4'd3, 11'h007);
        chk("t4_avail_sat0", 32'(bits_avail), 32'd0);
        marker_clear = 1'b1;
        req_len = 4'd0;
        #1;
        chk("t4_req_ready_clear", 32'(req_ready), 32'd0);
        @(negedge clk);
        marker_clear = 1'b0;
        chk("t4_cleared", 32'(marker_valid), 32'd0);
        chk("t4_byte_ready_back", 32'(byte_ready), 32'd1);

        // Full buffer backpressure, saturation, len 0, simultaneous byte+req
        put_byte(8'h11);
        put_byte(8'h22);
        put_byte(8'h33);
        put_byte(8'h44);
        chk("t5_avail32", 32'(bits_avail), 32'd32);
        chk("t5_full_not_ready", 32'(byte_ready), 32'd0);
        byte_in = 8'h55; byte_valid = 1'b1;
        req_len = 4'd8;  req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("t5_r8_bits", 32'(out_bits), 32'h011);
        chk("t5_avail24", 32'(bits_avail), 32'd24);
        chk("t5_ready_again", 32'(byte_ready), 32'd1);
        @(negedge clk);
        byte_valid = 1'b0;
        chk("t5_avail32b", 32'(bits_avail), 32'd32);
        do_req("t5_sat15", 4'd15, 11'h111);
        chk("t5_avail21", 32'(bits_avail), 32'd21);
        do_req("t5_len0", 4'd0, 11'h000);
        chk("t5_len0_avail", 32'(bits_avail), 32'd21);
        byte_in = 8'h66; byte_valid = 1'b1;
        do_req("t5_simul", 4'd5, 11'h013);
        byte_valid = 1'b0;
        chk("t5_simul_avail", 32'(bits_avail), 32'd24);
        do_req("t5_after_simul", 4'd11, 11'h222);
        chk("t5_avail13", 32'(bits_avail), 32'd13);

        // Reset while a marker is held and a result is in flight
        put_byte(8'hFF);
        put_byte(8'hC0);
        chk("t6_marker", 32'(marker_valid), 32'd1);
        req_len = 4'd4; req_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_inflight_vld", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_rst_out_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_avail", 32'(bits_avail), 32'd0);
        chk("t6_rst_marker", 32'(marker_valid), 32'd0);
        chk("t6_rst_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("t6_byte_ready", 32'(byte_ready), 32'd1);
        chk("t6_no_vld", 32'(out_valid), 32'd0);
        chk("t6_avail0", 32'(bits_avail), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
